spw_token_monitor: RTL
======================

# spw_token_monitor

Single-clock, oversampling SpaceWire receive-side token monitor for the DEBUG_VERILOG tree. It synchronises the Data/Strobe pair into `pclk` and recovers bits from D/S transitions. It locks on the first NULL, then decodes every token with odd-parity checking. Decoded events go into a ready/valid event FIFO, and per-class saturating counters are kept for lab and bench observation.

## Interface

Parameters:

- `CNT_WIDTH`, 16: width of each event counter.
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: synchroniser flops on `rx_din`/`rx_sin`; ≥2.
- `DISC_CYCLES`, 64: `pclk` cycles without a D/S transition that count as a disconnect.
- `TS_WIDTH`, 16: timestamp width; used only with `TOKEN_TIMESTAMP_EN`.

Ports:

- `pclk`, in, 1: sole clock.
- `rx_resetn`, in, 1: asynchronous, active-low reset.
- `rx_din`, in, 1: SpaceWire Data, asynchronous.
- `rx_sin`, in, 1: SpaceWire Strobe, asynchronous.
- `clear_counters`, in, 1: synchronous pulse; zeroes all counters and `fifo_overflow`.
- `evt_ready`, in, 1: consumer accepts the head event.
- `evt_valid`, out, 1: FIFO non-empty.
- `evt_data`, out, EVT_W: head event; `EVT_W`=11, or 11+`TS_WIDTH` with the timestamp feature.
- `cnt_sel`, in, 3: counter select.
- `cnt_value`, out, `CNT_WIDTH`: selected counter, registered.
- `link_state`, out, 2: 0 HUNT, 1 LOCKED.
- `parity_error`, out, 1: one-cycle pulse.
- `fifo_overflow`, out, 1: sticky.

## Operation

- **Bit recovery:** D and S are synchronised; a bit is recovered when (D^S) changes, and the sampled bit is the synchronised D. Bits arrive LSB-first.
- **FSM states:** HUNT, HDR (collect P and flag), CTRL (2 bits), DATA (8 bits).
- **HUNT:** slide an 8-bit window. Lock when the arrival order matches x,1,1,1,0,1,0,0 (ESC then FCT, ESC parity ignored). Go to HDR, count one NULL, and store the prior bits as 2'b00.
- **HDR → CTRL or DATA:** flag 1 selects CTRL; flag 0 selects DATA.
- **Parity rule:** P ^ flag ^ (XOR of the previous token's data or control bits) must equal 1. On failure: event type 6, `parity_error` pulse, return to HUNT.
- **Control codes (c1c0):**
  - 00 FCT
  - 01 EOP
  - 10 EEP
  - 11 ESC, which sets `esc_pend`.
- **While `esc_pend` is set:**
  - FCT → NULL.
  - Data → TIMECODE, with payload equal to the data byte.
  - EOP, EEP or ESC → type 7, payload 0x01, return to HUNT.
- **Disconnect:** no transition for `DISC_CYCLES` cycles while LOCKED → type 7, payload 0x02, return to HUNT.
- **Event word:** `{type[2:0], payload[7:0]}`, with the timestamp in the MSBs when enabled.
  - Types: 1 FCT, 2 EOP, 3 EEP, 4 NCHAR, 5 TIMECODE, 6 PARITY_ERR, 7 LINK_ERR.
  - Payload is 0 for FCT, EOP, EEP and PARITY_ERR.
  - NULLs are counted only, never queued.
  - ESC is never emitted on its own.
- **Counters (`cnt_sel`):**
  - 0 NULL, 1 FCT, 2 EOP, 3 EEP, 4 NCHAR, 5 TIMECODE, 6 PARITY_ERR, 7 dropped events.
  - All counters saturate at all-ones.
- **FIFO full, no pop:** the event is dropped, counter 7 increments, and `fifo_overflow` is set.
- **FIFO full, simultaneous pop:** the push is accepted.
- **`clear_counters` coinciding with an increment:** clear wins and the counter reads 0. `clear_counters` does not flush the FIFO.

## Timing

- **Reset values:** `evt_valid`=0, `evt_data`=0, `cnt_value`=0, `link_state`=0 (HUNT), `parity_error`=0, `fifo_overflow`=0, all counters 0, FIFO empty, `esc_pend`=0.
- **Input latency:** a pin transition is seen as a recovered bit `SYNC_STAGES`+1 cycles later.
- **Event latency:** if a token's last bit is recovered in cycle T, the counter updates and the FIFO write happen at T+1. `evt_valid` rises at T+2 when the FIFO was empty.
- **Handshake:** a pop occurs when `evt_valid`&&`evt_ready`. `evt_data` holds stable while `evt_valid`&&!`evt_ready`.
- **`cnt_value`:** reflects `cnt_sel` one cycle later.
- **Input rate:** the environment guarantees ≥3 `pclk` cycles per bit period.
- **Mid-operation reset:** a reset during any state returns to HUNT immediately and discards all FIFO contents.

## Configuration

- **`TOKEN_TIMESTAMP_EN` defined:**
  - A free-running `TS_WIDTH` counter, reset to 0 and wrapping, runs on `pclk`.
  - Its value at cycle T is captured into `evt_data[EVT_W-1:11]`.
- **`TOKEN_TIMESTAMP_EN` undefined:**
  - No timestamp logic is built.
  - `EVT_W`=11.

## Test plan

- **Null lock:** reset, then send 3 NULLs → `link_state`=1 after the first; counter0=3; `evt_valid` stays 0.
- **N-char and EOP:** NULL, N-char 0xA5, EOP, all with correct parity → events {4,0xA5} then {2,0x00}; counters 4 and 2 = 1.
- **Time code:** NULL, then ESC+data 0x3F → single event {5,0x3F}; counter5=1; no FCT or NCHAR counted.
- **Parity error:** flip P of the second N-char → event {6,0}, one-cycle `parity_error`, `link_state`=0; the next NULL relocks.
- **Overflow:** hold `evt_ready`=0 and send `FIFO_DEPTH`+3 FCTs → 8 events queued, counter7=3, `fifo_overflow`=1; `clear_counters` → all counters 0 and overflow 0 while the FIFO stays full.
- **Disconnect and escape error:** stop toggling for 64 cycles → {7,0x02}. Separately, ESC+EOP → {7,0x01} and HUNT.

Source files
------------

// File: rtl/spw_token_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : spw_token_monitor_if
//  Description : Ready/valid event stream carrying decoded SpaceWire tokens
//                from the monitor (master) to its consumer (slave).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals:
//    evt_valid  master->slave  head event present
//    evt_ready  slave->master  consumer accepts head event
//    evt_data   master->slave  {timestamp (optional), type[2:0], payload[7:0]}
// ============================================================================
interface spw_token_monitor_if #(
  parameter int EVT_W = 11
);
  logic             evt_valid;
  logic             evt_ready;
  logic [EVT_W-1:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/spw_token_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : spw_token_monitor
//  Description : Oversampling SpaceWire receive-side token monitor. Recovers
//                bits from D/S transitions, locks on the first NULL, decodes
//                tokens with odd-parity checking, queues decoded events in a
//                FIFO and keeps per-class saturating counters.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: TOKEN_TIMESTAMP_EN (adds TS_WIDTH timestamp in the
//  MSBs of each event word).
// ----------------------------------------------------------------------------
//  Ports:
//    pclk            in   sole clock
//    rx_resetn       in   asynchronous active-low reset
//    rx_din/rx_sin   in   SpaceWire Data/Strobe (asynchronous)
//    clear_counters  in   zeroes all counters and fifo_overflow
//    evt             mst  event stream (evt_valid/evt_ready/evt_data)
//    cnt_sel         in   counter select
//    cnt_value       out  selected counter, registered
//    link_state      out  0 HUNT, 1 LOCKED
//    parity_error    out  one-cycle pulse
//    fifo_overflow   out  sticky drop indicator
// ============================================================================
module spw_token_monitor #(
  parameter int CNT_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DISC_CYCLES = 64,
  parameter int TS_WIDTH    = 16
) (
  input  wire logic                 pclk,
  input  wire logic                 rx_resetn,
  input  wire logic                 rx_din,
  input  wire logic                 rx_sin,
  input  wire logic                 clear_counters,
  spw_token_monitor_if.master       evt,
  input  wire logic [2:0]           cnt_sel,
  output logic      [CNT_WIDTH-1:0] cnt_value,
  output logic      [1:0]           link_state,
  output logic                      parity_error,
  output logic                      fifo_overflow
);

`ifdef TOKEN_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int EVT_W = 11 + (TS_EN ? TS_WIDTH : 0);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int DW    = $clog2(DISC_CYCLES + 1);

  typedef enum logic [1:0] {S_HUNT = 2'd0, S_HDR = 2'd1, S_CTRL = 2'd2, S_DATA = 2'd3} state_t;

  // ---------------- Synchroniser and bit recovery ----------------
  logic [SYNC_STAGES-1:0] r_dsync, r_ssync;
  logic r_dsx, r_stb, r_bit;
  logic w_d, w_dsx;

  assign w_d   = r_dsync[SYNC_STAGES-1];
  assign w_dsx = w_d ^ r_ssync[SYNC_STAGES-1];

  // Extra register stage so a pin edge reaches the decoder SYNC_STAGES+1 cycles later.
  always_ff @(posedge pclk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      r_dsync <= '0;
      r_ssync <= '0;
      r_dsx   <= 1'b0;
      r_stb   <= 1'b0;
      r_bit   <= 1'b0;
    end else begin
      r_dsync <= {r_dsync[SYNC_STAGES-2:0], rx_din};
      r_ssync <= {r_ssync[SYNC_STAGES-2:0], rx_sin};
      r_dsx   <= w_dsx;
      r_stb   <= w_dsx ^ r_dsx;
      r_bit   <= w_d;
    end
  end

  // ---------------- Token decoder FSM ----------------
  state_t         r_state, w_state;
  logic [2:0]     r_cnt, w_cnt;
  logic [7:0]     r_sh, w_sh, r_win, w_win, w_byte;
  logic           r_p, w_p, r_prev, w_prev, r_esc, w_esc;
  logic [DW-1:0]  r_disc, w_disc;
  logic           w_ev, w_null, w_perr;
  logic [2:0]     w_ev_type;
  logic [7:0]     w_ev_pay;
  logic [1:0]     w_code;

  assign w_byte = {r_bit, r_sh[7:1]};
  assign w_code = {r_bit, r_sh[7]};

  always_ff @(posedge pclk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      r_state <= S_HUNT;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_win   <= '0;
      r_p     <= 1'b0;
      r_prev  <= 1'b0;
      r_esc   <= 1'b0;
      r_disc  <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sh    <= w_sh;
      r_win   <= w_win;
      r_p     <= w_p;
      r_prev  <= w_prev;
      r_esc   <= w_esc;
      r_disc  <= w_disc;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_sh      = r_sh;
    w_win     = r_win;
    w_p       = r_p;
    w_prev    = r_prev;
    w_esc     = r_esc;
    w_disc    = (r_state == S_HUNT || r_stb) ? '0 : r_disc + DW'(1);
    w_ev      = 1'b0;
    w_ev_type = 3'd0;
    w_ev_pay  = 8'd0;
    w_null    = 1'b0;
    w_perr    = 1'b0;

    if (r_stb) begin
      case (r_state)
        S_HUNT: begin
          w_win = {r_bit, r_win[7:1]};
          // Arrival order x,1,1,1,0,1,0,0 lands in window bits [1..7].
          if (w_win[7:1] == 7'b0010111) begin
            w_state = S_HDR;
            w_cnt   = '0;
            w_prev  = 1'b0;
            w_esc   = 1'b0;
            w_null  = 1'b1;
            w_win   = '0;
          end
        end
        S_HDR: begin
          if (r_cnt == 3'd0) begin
            w_p   = r_bit;
            w_cnt = 3'd1;
          end else begin
            w_cnt = '0;
            if ((r_p ^ r_bit ^ r_prev) == 1'b1) begin
              w_state = r_bit ? S_CTRL : S_DATA;
            end else begin
              w_state   = S_HUNT;
              w_ev      = 1'b1;
              w_ev_type = 3'd6;
              w_perr    = 1'b1;
              w_esc     = 1'b0;
            end
          end
        end
        S_CTRL: begin
          w_sh  = {r_bit, r_sh[7:1]};
          w_cnt = r_cnt + 3'd1;
          if (r_cnt == 3'd1) begin
            w_state = S_HDR;
            w_cnt   = '0;
            w_prev  = ^w_code;
            case (w_code)
              2'b00: begin
                if (r_esc) begin
                  w_null = 1'b1;
                  w_esc  = 1'b0;
                end else begin
                  w_ev      = 1'b1;
                  w_ev_type = 3'd1;
                end
              end
              2'b11: begin
                if (!r_esc) w_esc = 1'b1;
              end
              default: begin
                if (!r_esc) begin
                  w_ev      = 1'b1;
                  w_ev_type = (w_code == 2'b01) ? 3'd2 : 3'd3;
                end
              end
            endcase
            // Escape followed by anything but FCT or data is a link error.
            if (r_esc && w_code != 2'b00) begin
              w_state   = S_HUNT;
              w_ev      = 1'b1;
              w_ev_type = 3'd7;
              w_ev_pay  = 8'h01;
              w_esc     = 1'b0;
            end
          end
        end
        default: begin  // S_DATA
          w_sh  = {r_bit, r_sh[7:1]};
          w_cnt = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            w_state   = S_HDR;
            w_cnt     = '0;
            w_prev    = ^w_byte;
            w_ev      = 1'b1;
            w_ev_type = r_esc ? 3'd5 : 3'd4;
            w_ev_pay  = w_byte;
            w_esc     = 1'b0;
          end
        end
      endcase
    end else if (r_state != S_HUNT && r_disc == DW'(DISC_CYCLES - 1)) begin
      w_state   = S_HUNT;
      w_ev      = 1'b1;
      w_ev_type = 3'd7;
      w_ev_pay  = 8'h02;
      w_esc     = 1'b0;
      w_win     = '0;
      w_disc    = '0;
    end

    if (w_state == S_HUNT && r_state != S_HUNT) w_win = '0;
  end

  assign link_state = (r_state == S_HUNT) ? 2'd0 : 2'd1;

  // ---------------- Event word and pipeline stage ----------------
  logic [EVT_W-1:0] w_ev_word, r_ev_word;
  logic             r_ev_vld, r_null_q, r_perr;

`ifdef TOKEN_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;
  always_ff @(posedge pclk or negedge rx_resetn) begin
    if (!rx_resetn) r_ts <= '0;
    else            r_ts <= r_ts + TS_WIDTH'(1);
  end
  assign w_ev_word = {r_ts, w_ev_type, w_ev_pay};
`else
  assign w_ev_word = {w_ev_type, w_ev_pay};
`endif

  always_ff @(posedge pclk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      r_ev_vld  <= 1'b0;
      r_ev_word <= '0;
      r_null_q  <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_ev_vld  <= w_ev;
      r_ev_word <= w_ev_word;
      r_null_q  <= w_null;
      r_perr    <= w_perr;
    end
  end

  assign parity_error = r_perr;

  // ---------------- Event FIFO ----------------
  logic [EVT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wp, r_rp;
  logic             w_full, w_pop, w_push, w_drop;

  assign w_full         = (r_wp - r_rp) == (AW+1)'(FIFO_DEPTH);
  assign evt.evt_valid  = (r_wp != r_rp);
  assign evt.evt_data   = r_mem[r_rp[AW-1:0]];
  assign w_pop          = evt.evt_valid && evt.evt_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign w_push         = r_ev_vld && (!w_full || w_pop);
  assign w_drop         = r_ev_vld && w_full && !w_pop;

  always_ff @(posedge pclk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp[AW-1:0]] <= r_ev_word;
        r_wp                <= r_wp + (AW+1)'(1);
      end
      if (w_pop) r_rp <= r_rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge pclk or negedge rx_resetn) begin
    if (!rx_resetn)          fifo_overflow <= 1'b0;
    else if (clear_counters) fifo_overflow <= 1'b0;
    else if (w_drop)         fifo_overflow <= 1'b1;
  end

  // ---------------- Counters ----------------
  logic [CNT_WIDTH-1:0] r_cnt_arr [8];
  logic [7:0]           w_inc;

  always_comb begin
    w_inc    = '0;
    w_inc[0] = r_null_q;
    if (r_ev_vld && r_ev_word[10:8] != 3'd7) w_inc[r_ev_word[10:8]] = 1'b1;
    w_inc[7] = w_drop;
  end

  for (genvar g = 0; g < 8; g++) begin : g_cnt
    always_ff @(posedge pclk or negedge rx_resetn) begin
      if (!rx_resetn)
        r_cnt_arr[g] <= '0;
      else if (clear_counters)
        r_cnt_arr[g] <= '0;
      else if (w_inc[g] && r_cnt_arr[g] != {CNT_WIDTH{1'b1}})
        r_cnt_arr[g] <= r_cnt_arr[g] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge pclk or negedge rx_resetn) begin
    if (!rx_resetn) cnt_value <= '0;
    else            cnt_value <= r_cnt_arr[cnt_sel];
  end

endmodule
`default_nettype wire
